aurora_rx_lane_init: RTL
========================

# aurora_rx_lane_init

Receive-side, per-lane Aurora initialization and error monitor. It is the far-end counterpart of the transmit channel initializer: it consumes decoded 8b/10b symbols from one lane's decoder and produces the `aligned`/`verified`/`reset` status that the transmitter's simplex status inputs expect. It also forwards validated payload bytes once the lane is ready. The receive top instantiates one per lane (`MAX_LINKS` copies).

## Interface
Parameters:
- `RESET_CYCLES`, default 8: cycles held in `ST_RESET` before alignment starts.
- `ALIGN_COUNT`, default 4: error-free /K/ commas required to declare alignment.
- `VERIFY_COUNT`, default 64: /V/ symbols required to declare verification.
- `ERR_LIMIT`, default 8: error-bucket level that triggers a lane reset.
- `LEAK_PERIOD`, default 256: valid symbols per bucket decrement.

Ports:
- `clk`, in, 1: single clock for all logic.
- `rst`, in, 1: synchronous, active-high reset.
- `sym_valid`, in, 1: a decoded symbol is present this cycle.
- `sym_ctrl`, in, 1: the symbol is a K-code.
- `sym_data`, in, 8: decoded byte.
- `sym_err`, in, 1: disparity or code violation on this symbol.
- `rx_aligned`, out, 1: lane is aligned.
- `rx_verified`, out, 1: lane is verified.
- `rx_reset_req`, out, 1: one-cycle pulse when the lane drops to `ST_RESET` after an error.
- `data_valid`, out, 1: `data_out` holds a payload byte.
- `data_out`, out, 8: payload byte.

## Operation
- FSM states: `ST_RESET`, `ST_ALIGN`, `ST_VERIFY`, `ST_READY`.
- Good symbol: `sym_valid & ~sym_err`. Error symbol: `sym_valid & sym_err`. Cycles with `sym_valid=0` change no counter and cause no transition.
- `ST_RESET`:
  - Counts `RESET_CYCLES` clocks unconditionally, then moves to `ST_ALIGN`.
  - `rx_aligned = rx_verified = 0`.
- `ST_ALIGN`:
  - Each good /K/ (ctrl=1, data=`K_COMMA`) increments the align count.
  - An error symbol clears the count.
  - Any other good symbol leaves the count unchanged.
  - When the count reaches `ALIGN_COUNT`, move to `ST_VERIFY` and set `rx_aligned=1`.
- `ST_VERIFY`:
  - Each good /V/ (ctrl=1, data=`K_VER`) increments the verify count.
  - Good /K/, /R/ and /A/ are neutral.
  - An error symbol, a good non-idle K-code, or a good data symbol (ctrl=0) adds 1 to the error bucket.
  - Verify count reaching `VERIFY_COUNT` moves to `ST_READY` and sets `rx_verified=1`. The error bucket is cleared on this entry.
- `ST_READY`:
  - A good data symbol produces `data_valid=1` with `data_out=sym_data`.
  - K-codes are never forwarded.
  - An error symbol adds 1 to the bucket and is not forwarded.
- Error bucket (active in `ST_VERIFY` and `ST_READY`):
  - Saturating counter, `$clog2(ERR_LIMIT+1)` bits.
  - A leak counter counts valid symbols. Every `LEAK_PERIOD`-th valid symbol decrements the bucket if it is non-zero.
  - If an error and a leak fall on the same symbol, the net change is 0.
  - Bucket reaching `ERR_LIMIT`: pulse `rx_reset_req`, go to `ST_RESET`, clear all counters, drop `rx_aligned` and `rx_verified`.
- All counters use the minimum `$clog2` width and never wrap.

## Timing
- All outputs are registered. Reset values:
  - `rx_aligned = rx_verified = rx_reset_req = data_valid = 0`.
  - `data_out = 8'h00`.
  - State = `ST_RESET`, all counters 0.
- Asserting `rst` in any state returns the block to reset values on the next edge. There is no partial state retention.
- Latency is 1 cycle: the edge that samples the completing symbol also updates the state and the status outputs.
- `data_valid` and `data_out` follow the input symbol by exactly 1 cycle. `data_valid` is 0 in every state except `ST_READY`.
- `rx_reset_req` is high for exactly one cycle, the cycle the state register first reads `ST_RESET`. It does not pulse after `rst`.
- In the cycle after a lane reset, `data_valid=0` even if that cycle's input symbol is a good data byte.

## Structure
- Add to `aurora_pkg`:
  - K-code localparams: `K_COMMA=8'hBC`, `K_R=8'h1C`, `K_A=8'h7C`, `K_VER=8'hF7`.
  - Enum `rx_init_state_e` holding the four states.
- Sub-module `aurora_rx_err_bucket`: the saturating leaky bucket.
  - Inputs: `clk`, `rst`, `clear`, `tick` (valid symbol), `err`.
  - Output: `limit_hit`.

## Test plan
- Reset, then 4 good /K/: `rx_aligned` rises on the edge sampling the 4th /K/ (earliest at cycle `RESET_CYCLES`+4). `rx_verified` stays 0.
- In `ST_ALIGN`, send /K/ /K/ err /K/ /K/ /K/: no alignment until the 4th /K/ after the error.
- After alignment, send 64 /V/ interleaved with /R/ and /A/: `rx_verified=1` after the 64th /V/. Then data bytes 8'h00..8'hFF appear on `data_out` one cycle later, in order.
- In `ST_READY`, 8 error symbols within 256 valid symbols: one `rx_reset_req` pulse, and `rx_aligned`/`rx_verified` drop on the same edge. The same 8 errors spaced 300 symbols apart cause no reset.
- Error symbol coinciding with the 256th valid symbol (the leak point): bucket value unchanged. Check the bucket through `aurora_rx_err_bucket`.
- Assert `rst` mid-verify (verify count 30): all outputs return to reset values next cycle, and a full 64 /V/ is required again.

Source files
------------

// File: rtl/aurora_pkg.sv
// aurora_pkg
// Shared definitions for the Aurora lane logic: K-code byte values and the
// receive-side lane initialization state encoding.
package aurora_pkg;

   // K-code byte values (sym_ctrl = 1)
   localparam logic [7:0] K_COMMA = 8'hBC;  // /K/ comma, used for alignment
   localparam logic [7:0] K_R     = 8'h1C;  // /R/ idle
   localparam logic [7:0] K_A     = 8'h7C;  // /A/ idle
   localparam logic [7:0] K_VER   = 8'hF7;  // /V/ verification symbol

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_VERIFY = 2'd2,
      ST_READY  = 2'd3
   } rx_init_state_e;

   // True for the K-codes that may appear as idle fill during verification.
   function automatic logic is_idle_k(input logic [7:0] data);
      return (data == K_COMMA) || (data == K_R) || (data == K_A);
   endfunction

endpackage

// File: rtl/aurora_rx_err_bucket.sv
// aurora_rx_err_bucket
// Saturating leaky error bucket. Each err adds one; every LEAK_PERIOD-th tick
// removes one (if non-zero). An error on the leak tick nets to no change.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : zero the bucket and the leak counter on this edge
//   tick       : a valid symbol was seen (advances the leak counter)
//   err        : an error symbol was seen (only asserted together with tick)
//   limit_hit  : combinational; this symbol brings the bucket to ERR_LIMIT.
//                Independent of clear so the caller may feed it back into clear.
module aurora_rx_err_bucket
   import aurora_pkg::*;
#(
   parameter int ERR_LIMIT   = 8,
   parameter int LEAK_PERIOD = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   input  logic err,
   output logic limit_hit
);

   localparam int BW = $clog2(ERR_LIMIT + 1);
   localparam int LW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
   localparam logic [BW-1:0] LIMIT     = BW'(ERR_LIMIT);
   localparam logic [BW-1:0] LIMIT_M1  = BW'(ERR_LIMIT - 1);
   localparam logic [LW-1:0] LEAK_LAST = LW'(LEAK_PERIOD - 1);

   logic [BW-1:0] bucket_q, bucket_d;
   logic [LW-1:0] leak_cnt_q, leak_cnt_d;
   logic          leak, inc, dec;

   // Kept apart from the next-state block so limit_hit never depends on clear.
   always_comb begin
      leak      = tick & (leak_cnt_q == LEAK_LAST);
      inc       = err & ~leak & (bucket_q != LIMIT);
      dec       = leak & ~err & (bucket_q != '0);
      limit_hit = inc & (bucket_q == LIMIT_M1);
   end

   always_comb begin
      bucket_d   = bucket_q;
      leak_cnt_d = leak_cnt_q;
      if (clear) begin
         bucket_d   = '0;
         leak_cnt_d = '0;
      end else begin
         if (tick) begin
            leak_cnt_d = leak ? '0 : leak_cnt_q + LW'(1);
         end
         if (inc) begin
            bucket_d = bucket_q + BW'(1);
         end else if (dec) begin
            bucket_d = bucket_q - BW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bucket_q   <= '0;
         leak_cnt_q <= '0;
      end else begin
         bucket_q   <= bucket_d;
         leak_cnt_q <= leak_cnt_d;
      end
   end

endmodule

// File: rtl/aurora_rx_lane_init.sv
// aurora_rx_lane_init
// Per-lane receive initialization and error monitor. Walks RESET -> ALIGN ->
// VERIFY -> READY from decoded 8b/10b symbols, reports aligned/verified status,
// forwards payload bytes once READY, and drops the lane back to RESET when the
// leaky error bucket fills.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   sym_valid/ctrl/data[7:0]/err    : decoded symbol from the lane decoder
//   rx_aligned, rx_verified         : registered lane status
//   rx_reset_req                    : one-cycle pulse on error-driven lane reset
//   data_valid, data_out[7:0]       : forwarded payload byte (1-cycle latency)
module aurora_rx_lane_init
   import aurora_pkg::*;
#(
   parameter int RESET_CYCLES = 8,
   parameter int ALIGN_COUNT  = 4,
   parameter int VERIFY_COUNT = 64,
   parameter int ERR_LIMIT    = 8,
   parameter int LEAK_PERIOD  = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sym_valid,
   input  logic       sym_ctrl,
   input  logic [7:0] sym_data,
   input  logic       sym_err,
   output logic       rx_aligned,
   output logic       rx_verified,
   output logic       rx_reset_req,
   output logic       data_valid,
   output logic [7:0] data_out
);

   localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int AW = $clog2(ALIGN_COUNT + 1);
   localparam int VW = $clog2(VERIFY_COUNT + 1);
   localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
   localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_COUNT - 1);
   localparam logic [VW-1:0] VER_LAST   = VW'(VERIFY_COUNT - 1);

   rx_init_state_e state_q, state_d;
   logic [RW-1:0]  reset_cnt_q, reset_cnt_d;
   logic [AW-1:0]  align_cnt_q, align_cnt_d;
   logic [VW-1:0]  verify_cnt_q, verify_cnt_d;
   logic           rx_aligned_q, rx_aligned_d;
   logic           rx_verified_q, rx_verified_d;
   logic           rx_reset_req_q, rx_reset_req_d;
   logic           data_valid_q, data_valid_d;
   logic [7:0]     data_out_q, data_out_d;

   logic good_sym, err_sym, good_k, good_v, active, ver_done;
   logic bucket_err, bucket_clear, limit_hit;

   assign good_sym = sym_valid & ~sym_err;
   assign err_sym  = sym_valid & sym_err;
   assign good_k   = good_sym & sym_ctrl & (sym_data == K_COMMA);
   assign good_v   = good_sym & sym_ctrl & (sym_data == K_VER);
   assign active   = (state_q == ST_VERIFY) || (state_q == ST_READY);
   assign ver_done = (state_q == ST_VERIFY) & good_v & (verify_cnt_q == VER_LAST);

   // While verifying, anything but /V/ or idle K-codes counts against the lane;
   // once ready only real code errors do.
   always_comb begin
      bucket_err = 1'b0;
      if (state_q == ST_VERIFY) begin
         bucket_err = err_sym |
                      (good_sym & (~sym_ctrl | ~(is_idle_k(sym_data) | (sym_data == K_VER))));
      end else if (state_q == ST_READY) begin
         bucket_err = err_sym;
      end
   end

   // Bucket only runs in VERIFY/READY and restarts fresh on READY entry and on
   // an error-driven lane reset.
   assign bucket_clear = ~active | ver_done | limit_hit;

   aurora_rx_err_bucket #(
      .ERR_LIMIT   (ERR_LIMIT),
      .LEAK_PERIOD (LEAK_PERIOD)
   ) u_err_bucket (
      .clk       (clk),
      .rst       (rst),
      .clear     (bucket_clear),
      .tick      (sym_valid & active),
      .err       (bucket_err),
      .limit_hit (limit_hit)
   );

   always_comb begin
      state_d        = state_q;
      reset_cnt_d    = reset_cnt_q;
      align_cnt_d    = align_cnt_q;
      verify_cnt_d   = verify_cnt_q;
      rx_reset_req_d = 1'b0;
      data_valid_d   = 1'b0;
      data_out_d     = data_out_q;

      case (state_q)
         ST_RESET: begin
            if (reset_cnt_q == RST_LAST) begin
               state_d     = ST_ALIGN;
               reset_cnt_d = '0;
            end else begin
               reset_cnt_d = reset_cnt_q + RW'(1);
            end
         end
         ST_ALIGN: begin
            if (err_sym) begin
               align_cnt_d = '0;
            end else if (good_k) begin
               if (align_cnt_q == ALIGN_LAST) begin
                  state_d     = ST_VERIFY;
                  align_cnt_d = '0;
               end else begin
                  align_cnt_d = align_cnt_q + AW'(1);
               end
            end
         end
         ST_VERIFY: begin
            if (limit_hit) begin
               state_d        = ST_RESET;
               verify_cnt_d   = '0;
               rx_reset_req_d = 1'b1;
            end else if (good_v) begin
               if (ver_done) begin
                  state_d      = ST_READY;
                  verify_cnt_d = '0;
               end else begin
                  verify_cnt_d = verify_cnt_q + VW'(1);
               end
            end
         end
         ST_READY: begin
            if (limit_hit) begin
               state_d        = ST_RESET;
               rx_reset_req_d = 1'b1;
            end else if (good_sym & ~sym_ctrl) begin
               data_valid_d = 1'b1;
               data_out_d   = sym_data;
            end
         end
         default: state_d = ST_RESET;
      endcase

      rx_aligned_d  = (state_d == ST_VERIFY) || (state_d == ST_READY);
      rx_verified_d = (state_d == ST_READY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_RESET;
         reset_cnt_q    <= '0;
         align_cnt_q    <= '0;
         verify_cnt_q   <= '0;
         rx_aligned_q   <= 1'b0;
         rx_verified_q  <= 1'b0;
         rx_reset_req_q <= 1'b0;
         data_valid_q   <= 1'b0;
         data_out_q     <= 8'h00;
      end else begin
         state_q        <= state_d;
         reset_cnt_q    <= reset_cnt_d;
         align_cnt_q    <= align_cnt_d;
         verify_cnt_q   <= verify_cnt_d;
         rx_aligned_q   <= rx_aligned_d;
         rx_verified_q  <= rx_verified_d;
         rx_reset_req_q <= rx_reset_req_d;
         data_valid_q   <= data_valid_d;
         data_out_q     <= data_out_d;
      end
   end

   assign rx_aligned   = rx_aligned_q;
   assign rx_verified  = rx_verified_q;
   assign rx_reset_req = rx_reset_req_q;
   assign data_valid   = data_valid_q;
   assign data_out     = data_out_q;

endmodule
